// File: rtl/ifm_pf_pkg.sv
// Shared types and tile-geometry helpers for the IFM tile prefetcher.
package ifm_pf_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT, DONE} pf_state_e;

  function automatic int lm(input int s, input int ksize, input int poy);
    return ksize + s * (poy - 1);
  endfunction

  function automatic int nrb(input int s, input int ksize, input int poy, input int ih);
    return (ih - lm(s, ksize, poy)) / (s * poy) + 1;
  endfunction

endpackage

// File: rtl/ifm_pp_ram.sv
// Ping-pong tile store: two banks of ROWS x BURST words, one write port, one registered read port.
module ifm_pp_ram #(
  parameter int DW    = 32,
  parameter int ROWS  = 7,
  parameter int BURST = 32,
  parameter int RW    = $clog2(ROWS),
  parameter int CW    = $clog2(BURST)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          wbank,
  input  logic [RW-1:0] wrow,
  input  logic [CW-1:0] wcol,
  input  logic [DW-1:0] wdata,
  input  logic          rbank,
  input  logic [RW-1:0] rrow,
  input  logic [CW-1:0] rcol,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 2 * ROWS * BURST;
  localparam int AIW   = $clog2(DEPTH);

  logic [DW-1:0]  mem [DEPTH];
  logic [AIW-1:0] widx;
  logic [AIW-1:0] ridx;
  logic [DW-1:0]  rdata_d;
  logic [DW-1:0]  rdata_q;

  always_comb begin
    widx    = AIW'((int'(wbank) * ROWS + int'(wrow)) * BURST + int'(wcol));
    ridx    = AIW'((int'(rbank) * ROWS + int'(rrow)) * BURST + int'(rcol));
    rdata_d = mem[ridx];
  end

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  // Read register is cleared so the output reads zero straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ifm_tile_prefetcher.sv
// Autonomous IFM walker: fetches LM-row x BURST-word tiles over AXI read into a ping-pong bank pair.
module ifm_tile_prefetcher
  import ifm_pf_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int BURST = 32,
  parameter int KSIZE = 3,
  parameter int POY   = 3,
  parameter int IW    = 224,
  parameter int IH    = 224,
  parameter int ROWS  = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic [AW-1:0]            cfg_base,
  input  logic                     cfg_stride2,
  output logic                     busy,
  output logic [AW-1:0]            araddr,
  output logic [7:0]               arlen,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [DW-1:0]            rdata,
  input  logic                     rvalid,
  input  logic                     rlast,
  output logic                     rready,
  output logic                     blk_valid,
  output logic                     blkend,
  input  logic                     blk_release,
  input  logic [$clog2(ROWS)-1:0]  rd_row,
  input  logic [$clog2(BURST)-1:0] rd_col,
  output logic [DW-1:0]            rd_data,
  output logic                     mapend,
  output logic                     err
);

  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(BURST);
  localparam int NCT  = IW / BURST;
  localparam int LM1  = lm(1, KSIZE, POY);
  localparam int LM2  = lm(2, KSIZE, POY);
  localparam int NRB1 = nrb(1, KSIZE, POY, IH);
  localparam int NRB2 = nrb(2, KSIZE, POY, IH);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);
  localparam logic [AW-1:0] STEP1     = AW'(POY * IW);
  localparam logic [AW-1:0] STEP2     = AW'(2 * POY * IW);
  localparam logic [AW-1:0] COL_STEP  = AW'(BURST);
  localparam logic [AW-1:0] ROW_STEP  = AW'(IW);

  pf_state_e     state_q, state_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] araddr_q, araddr_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [15:0]   b_q, b_d;
  logic [15:0]   c_q, c_d;
  logic          s2_q, s2_d;
  logic [AW-1:0] blk_base_q, blk_base_d;
  logic [AW-1:0] tile_base_q, tile_base_d;
  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic [1:0]    full_q, full_d;
  logic          err_q, err_d;
  logic          blkend_q, blkend_d;
  logic          mapend_q, mapend_d;

  logic [RW-1:0] lm_last;
  logic [15:0]   nrb_last;
  logic          last_tile;
  logic [AW-1:0] blk_step;
  logic [AW-1:0] next_tile;
  logic          beat_fire;
  logic          ram_we;

  assign lm_last   = s2_q ? RW'(LM2 - 1) : RW'(LM1 - 1);
  assign nrb_last  = s2_q ? 16'(NRB2 - 1) : 16'(NRB1 - 1);
  assign last_tile = (b_q == nrb_last) && (c_q == 16'(NCT - 1));
  assign blk_step  = s2_q ? STEP2 : STEP1;
  assign beat_fire = (state_q == DATA) && rvalid && rready_q;
  assign ram_we    = beat_fire;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    r_d         = r_q;
    beat_d      = beat_q;
    b_d         = b_q;
    c_d         = c_q;
    s2_d        = s2_q;
    blk_base_d  = blk_base_q;
    tile_base_d = tile_base_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    full_d      = full_q;
    err_d       = err_q;
    mapend_d    = 1'b0;
    next_tile   = tile_base_q + COL_STEP;

    // A release is applied first so a same-cycle fill completion sees the freed bank.
    if (blk_release && full_q[rd_sel_q]) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          s2_d        = cfg_stride2;
          blk_base_d  = cfg_base;
          tile_base_d = cfg_base;
          araddr_d    = cfg_base;
          arvalid_d   = 1'b1;
          busy_d      = 1'b1;
          r_d         = '0;
          beat_d      = '0;
          b_d         = '0;
          c_d         = '0;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (beat_fire) begin
          if (rlast != (beat_q == LAST_BEAT)) err_d = 1'b1;
          if (!rlast) begin
            beat_d = beat_q + CW'(1);
          end else begin
            beat_d   = '0;
            rready_d = 1'b0;
            if (r_q != lm_last) begin
              r_d       = r_q + RW'(1);
              araddr_d  = araddr_q + ROW_STEP;
              arvalid_d = 1'b1;
              state_d   = ADDR;
            end else begin
              full_d[wr_sel_q] = 1'b1;
              wr_sel_d         = ~wr_sel_q;
              r_d              = '0;
              if (last_tile) begin
                state_d = DONE;
              end else begin
                if (c_q == 16'(NCT - 1)) begin
                  c_d        = '0;
                  b_d        = b_q + 16'd1;
                  next_tile  = blk_base_q + blk_step;
                  blk_base_d = next_tile;
                end else begin
                  c_d = c_q + 16'd1;
                end
                tile_base_d = next_tile;
                araddr_d    = next_tile;
                if (!full_d[~wr_sel_q]) begin
                  arvalid_d = 1'b1;
                  state_d   = ADDR;
                end else begin
                  state_d = WAIT;
                end
              end
            end
          end
        end
      end
      WAIT: begin
        if (!full_d[wr_sel_q]) begin
          arvalid_d = 1'b1;
          state_d   = ADDR;
        end
      end
      DONE: begin
        if (blk_release && full_q[rd_sel_q] && (full_d == 2'b00)) begin
          busy_d   = 1'b0;
          mapend_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new tile is presented either by a fill landing in the rd bank or by a toggle onto a full bank.
    blkend_d = full_d[rd_sel_d] && (!full_q[rd_sel_q] || (rd_sel_d != rd_sel_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      r_q         <= '0;
      beat_q      <= '0;
      b_q         <= '0;
      c_q         <= '0;
      s2_q        <= 1'b0;
      blk_base_q  <= '0;
      tile_base_q <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      full_q      <= 2'b00;
      err_q       <= 1'b0;
      blkend_q    <= 1'b0;
      mapend_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      r_q         <= r_d;
      beat_q      <= beat_d;
      b_q         <= b_d;
      c_q         <= c_d;
      s2_q        <= s2_d;
      blk_base_q  <= blk_base_d;
      tile_base_q <= tile_base_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      full_q      <= full_d;
      err_q       <= err_d;
      blkend_q    <= blkend_d;
      mapend_q    <= mapend_d;
    end
  end

  ifm_pp_ram #(
    .DW    (DW),
    .ROWS  (ROWS),
    .BURST (BURST)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .wbank (wr_sel_q),
    .wrow  (r_q),
    .wcol  (beat_q),
    .wdata (rdata),
    .rbank (rd_sel_q),
    .rrow  (rd_row),
    .rcol  (rd_col),
    .rdata (rd_data)
  );

  assign busy      = busy_q;
  assign araddr    = araddr_q;
  assign arlen     = 8'(BURST - 1);
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign blk_valid = full_q[rd_sel_q];
  assign blkend    = blkend_q;
  assign mapend    = mapend_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ifm_tile_prefetcher.sv
// Directed bench for ifm_tile_prefetcher: AXI read slave model, consumer, hand-computed addresses.
module tb_ifm_tile_prefetcher;

  localparam int BURST = 32;
  localparam int IW    = 224;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [31:0] cfg_base;
  logic        cfg_stride2;
  logic        busy;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rlast;
  logic        rready;
  logic        blk_valid;
  logic        blkend;
  logic        blk_release;
  logic [2:0]  rd_row;
  logic [4:0]  rd_col;
  logic [31:0] rd_data;
  logic        mapend;
  logic        err;

  always #5 clk = ~clk;

  ifm_tile_prefetcher dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base(cfg_base), .cfg_stride2(cfg_stride2),
    .busy(busy), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .blk_valid(blk_valid), .blkend(blkend), .blk_release(blk_release),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data), .mapend(mapend), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mv(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h00005A5A;
  endfunction

  // Slave model knobs (written by main only) and address log (written by slave only).
  logic        ar_stall = 1'b0;
  logic        r_stall  = 1'b0;
  int          inj_idx  = -1;
  logic [31:0] ar_log[$];

  initial begin
    logic        active;
    logic        rv;
    logic [31:0] cur;
    int          beat;
    int          last_b;
    active = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    cur = '0; beat = 0; last_b = BURST - 1;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        active = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      end else begin
        if (active) begin
          rv     = r_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
          rvalid = rv;
          rdata  = mv(cur + 32'(beat));
          rlast  = (beat == last_b);
          if (rv && rready) begin
            if (rlast) active = 1'b0;
            else       beat++;
          end
        end else begin
          rvalid = 1'b0;
          rlast  = 1'b0;
        end
        arready = ar_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (!active && arvalid && arready) begin
          last_b = (ar_log.size() == inj_idx) ? 30 : BURST - 1;
          ar_log.push_back(araddr);
          cur    = araddr;
          beat   = 0;
          active = 1'b1;
        end
      end
    end
  end

  int blkend_cnt = 0;
  int mapend_cnt = 0;
  always @(posedge clk) begin
    if (blkend) blkend_cnt <= blkend_cnt + 1;
    if (mapend) mapend_cnt <= mapend_cnt + 1;
  end

  int a0, be0, me0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; blk_release = 1'b0; cfg_start = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic start_walk(input logic [31:0] base, input logic s2);
    cfg_base = base; cfg_stride2 = s2; cfg_start = 1'b1;
    a0 = ar_log.size(); be0 = blkend_cnt; me0 = mapend_cnt;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_busy"},    busy,      0);
    check({pfx, "_arvalid"}, arvalid,   0);
    check({pfx, "_araddr"},  araddr,    0);
    check({pfx, "_rready"},  rready,    0);
    check({pfx, "_blkvld"},  blk_valid, 0);
    check({pfx, "_blkend"},  blkend,    0);
    check({pfx, "_mapend"},  mapend,    0);
    check({pfx, "_err"},     err,       0);
    check({pfx, "_rddata"},  rd_data,   0);
  endtask

  initial begin
    int cyc;
    int first_be;
    rst = 1'b1; cfg_start = 1'b0; cfg_base = '0; cfg_stride2 = 1'b0;
    blk_release = 1'b0; rd_row = '0; rd_col = '0;
    repeat (3) tick();
    check_outputs_zero("rst");
    rst = 1'b0;
    tick();

    // Stride 2 full map walk with an always-ready consumer.
    start_walk(32'h0, 1'b1);
    cyc = 0; first_be = -1;
    while (mapend_cnt == me0 && cyc < 70000) begin
      blk_release = blk_valid;
      if (blkend && first_be < 0) first_be = cyc;
      tick();
      cyc++;
    end
    blk_release = 1'b0;
    check("t1_done_in_time", cyc < 70000, 1);
    for (int i = 0; i < 7; i++) check("t1_araddr", ar_log[a0 + i], 32'(i * IW));
    check("t1_first_blkend", (first_be >= 7 * BURST) && (first_be <= 7 * (BURST + 2)), 1);
    tick();
    check("t1_blkend_cnt", blkend_cnt - be0, 259);
    check("t1_mapend_cnt", mapend_cnt - me0, 1);
    check("t1_bursts", ar_log.size() - a0, 1813);
    check("t1_last_araddr", ar_log[ar_log.size() - 1], 32'd49920);
    check("t1_idle", busy, 0);

    // Stride 1, odd base: spot-check tile addresses.
    do_reset();
    start_walk(32'hA, 1'b0);
    cyc = 0;
    while (ar_log.size() < a0 + 46 && cyc < 3000) begin
      blk_release = blk_valid;
      tick();
      cyc++;
    end
    blk_release = 1'b0;
    check("t2_progress", cyc < 3000, 1);
    check("t2_t00_r4", ar_log[a0 + 4], 32'hA + 4 * IW);
    check("t2_t01_r0", ar_log[a0 + 5], 32'hA + 32);
    check("t2_t02_r0", ar_log[a0 + 10], 32'hA + 64);
    check("t2_t12_r0", ar_log[a0 + 45], 32'hA + 3 * IW + 64);

    // Consumer never releases: two tiles land, then the walker parks.
    do_reset();
    start_walk(32'h0, 1'b1);
    repeat (600) tick();
    check("t3_arvalid", arvalid, 0);
    check("t3_blkvld", blk_valid, 1);
    check("t3_busy", busy, 1);
    check("t3_bursts", ar_log.size() - a0, 14);
    cfg_base = 32'd999; cfg_stride2 = 1'b0; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    blk_release = 1'b1;
    tick();
    blk_release = 1'b0;
    check("t3_blkend_after_rel", blkend, 1);
    cyc = 0;
    while (!arvalid && cyc < 2) begin tick(); cyc++; end
    check("t3_arvalid_resume", arvalid, 1);
    cyc = 0;
    while (ar_log.size() < a0 + 15 && cyc < 10) begin tick(); cyc++; end
    check("t3_resume_addr", ar_log[a0 + 14], 32'd64);

    // Random stalls on both channels; read back three tiles word by word.
    do_reset();
    ar_stall = 1'b1; r_stall = 1'b1;
    start_walk(32'h100, 1'b0);
    for (int t = 0; t < 3; t++) begin
      cyc = 0;
      while (!blk_valid && cyc < 5000) begin tick(); cyc++; end
      check("t4_tile_ready", blk_valid, 1);
      for (int r = 0; r < 5; r++) begin
        for (int k = 0; k < BURST; k++) begin
          rd_row = 3'(r); rd_col = 5'(k);
          tick();
          check("t4_data", rd_data, mv(32'h100 + 32'(r * IW + t * BURST + k)));
        end
      end
      blk_release = 1'b1;
      tick();
      blk_release = 1'b0;
    end
    ar_stall = 1'b0; r_stall = 1'b0;

    // Short burst (rlast on beat 30) sets sticky err; next bursts unaffected.
    do_reset();
    check("t5_err_clear", err, 0);
    inj_idx = ar_log.size();
    start_walk(32'h0, 1'b1);
    cyc = 0;
    while (ar_log.size() < a0 + 3 && cyc < 500) begin
      blk_release = blk_valid;
      tick();
      cyc++;
    end
    check("t5_err_set", err, 1);
    check("t5_row1", ar_log[a0 + 1], 32'(IW));
    check("t5_row2", ar_log[a0 + 2], 32'(2 * IW));
    repeat (100) begin blk_release = blk_valid; tick(); end
    blk_release = 1'b0;
    check("t5_err_sticky", err, 1);
    inj_idx = -1;

    // Reset in the middle of a burst, then restart.
    do_reset();
    start_walk(32'h40, 1'b0);
    cyc = 0;
    while (!rready && cyc < 20) begin tick(); cyc++; end
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check_outputs_zero("t6");
    rst = 1'b0;
    tick();
    check("t6_rready_held", rready, 0);
    start_walk(32'h40, 1'b0);
    cyc = 0;
    while (ar_log.size() == a0 && cyc < 10) begin tick(); cyc++; end
    check("t6_restart_addr", ar_log[a0], 32'h40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
